// File: rtl/pll_gated_counter.sv
// Lock-qualified up/down counter with prescaler, wrap/saturate bounds and synchronous load.
// Optional macro LOCK_SYNC_EN inserts a 2-flop synchroniser on `locked`.
module pll_gated_counter #(
    parameter int WIDTH         = 4,
    parameter int PRESCALE      = 1,
    parameter int SETTLE_CYCLES = 16,
    parameter int SATURATE      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             running,
    output logic             tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_SETTLE    = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    logic             lock_q;
    logic [1:0]       state_q,   state_d;
    logic [SW-1:0]    scnt_q,    scnt_d;
    logic [PW-1:0]    pcnt_q,    pcnt_d;
    logic [WIDTH-1:0] out_q,     out_d;
    logic             running_q, running_d;
    logic             tick_q,    tick_d;

`ifdef LOCK_SYNC_EN
    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], locked};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= sync_d;
    end

    assign lock_q = sync_q[1];
`else
    assign lock_q = locked;
`endif

    // One count step in the selected direction, wrapping or holding at the bounds.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] v, input logic down);
        if (!down) begin
            if (v == {WIDTH{1'b1}}) return (SATURATE != 0) ? v : '0;
            return v + WIDTH'(1);
        end
        if (v == '0) return (SATURATE != 0) ? v : {WIDTH{1'b1}};
        return v - WIDTH'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        pcnt_d  = pcnt_q;
        out_d   = out_q;
        tick_d  = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_q) begin
                    state_d = ST_SETTLE;
                    scnt_d  = '0;
                end
            end
            ST_SETTLE: begin
                if (!lock_q)              state_d = ST_WAIT_LOCK;
                else if (scnt_q == S_LAST) state_d = ST_RUN;
                else                       scnt_d  = scnt_q + SW'(1);
            end
            ST_RUN: begin
                if (!lock_q) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Loads and steps only happen in RUN cycles that keep lock; a lock drop suppresses both.
        if (state_q == ST_RUN && lock_q) begin
            if (load) begin
                out_d  = load_val;
                pcnt_d = '0;
            end else if (en) begin
                if (pcnt_q == P_LAST) begin
                    pcnt_d = '0;
                    out_d  = step_value(out_q, dir);
                    tick_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
        end else begin
            pcnt_d = '0;
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_LOCK;
            scnt_q    <= '0;
            pcnt_q    <= '0;
            out_q     <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            pcnt_q    <= pcnt_d;
            out_q     <= out_d;
            running_q <= running_d;
            tick_q    <= tick_d;
        end
    end

    assign out     = out_q;
    assign running = running_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_pll_gated_counter.sv
// Bench for pll_gated_counter: three parameterisations driven in parallel, checked
// against a consecutive-lock-count reference model plus directed vectors.
module tb_pll_gated_counter;

    localparam int W = 4;
    localparam int SETTLE = 16;
`ifdef LOCK_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         locked = 1'b0;
    logic         en = 1'b0;
    logic         dir = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] o_out [3];
    logic         o_run [3];
    logic         o_tick [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // 0: wrap, prescale 1   1: saturate, prescale 1   2: wrap, prescale 5
    pll_gated_counter #(.WIDTH(W), .PRESCALE(1), .SETTLE_CYCLES(SETTLE), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .locked(locked), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .out(o_out[0]), .running(o_run[0]), .tick(o_tick[0]));
    pll_gated_counter #(.WIDTH(W), .PRESCALE(1), .SETTLE_CYCLES(SETTLE), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .locked(locked), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .out(o_out[1]), .running(o_run[1]), .tick(o_tick[1]));
    pll_gated_counter #(.WIDTH(W), .PRESCALE(5), .SETTLE_CYCLES(SETTLE), .SATURATE(0)) dut_p (
        .clk(clk), .rst(rst), .locked(locked), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .out(o_out[2]), .running(o_run[2]), .tick(o_tick[2]));

    // Reference model: running once lock has been seen on SETTLE+1 consecutive edges.
    int m_ps  [3] = '{1, 1, 5};
    int m_sat [3] = '{0, 1, 0};
    int m_out [3];
    int m_p   [3];
    int m_tick[3];
    int m_consec;
    int m_hist[$];

    task automatic model_reset();
        m_consec = 0;
        m_hist = {};
        for (int k = 0; k < 3; k++) begin
            m_out[k] = 0; m_p[k] = 0; m_tick[k] = 0;
        end
    endtask

    task automatic model_edge();
        int lk;
        bit run_before;
        m_hist.push_back(int'(locked));
        if (m_hist.size() > SYNC_LAT) lk = m_hist.pop_front();
        else lk = 0;
        run_before = (m_consec >= SETTLE + 1);
        for (int k = 0; k < 3; k++) begin
            m_tick[k] = 0;
            if (run_before && lk == 1) begin
                if (load) begin
                    m_out[k] = int'(load_val); m_p[k] = 0;
                end else if (en) begin
                    m_p[k] = m_p[k] + 1;
                    if (m_p[k] == m_ps[k]) begin
                        int nv;
                        m_p[k] = 0;
                        m_tick[k] = 1;
                        nv = dir ? m_out[k] - 1 : m_out[k] + 1;
                        if (nv < 0 || nv > (1 << W) - 1)
                            nv = (m_sat[k] != 0) ? m_out[k] : (nv + (1 << W)) % (1 << W);
                        m_out[k] = nv;
                    end
                end
            end else begin
                m_p[k] = 0;
            end
        end
        m_consec = (lk == 1) ? m_consec + 1 : 0;
        if (m_consec > 1000) m_consec = 1000;
    endtask

    task automatic check(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("model_out", k, int'(o_out[k]), m_out[k]);
            check("model_tick", k, int'(o_tick[k]), m_tick[k]);
            check("model_running", k, int'(o_run[k]), int'(m_consec >= SETTLE + 1));
        end
    endtask

    // Edges from the first one sampling the current inputs until running matches `want`.
    task automatic edges_until_running(input bit want, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step_clk();
            if (o_run[0] == want) begin n = i; break; end
        end
    endtask

    typedef struct {
        bit ld; int lv; bit en; bit dir;
        int exp_w; int exp_s; int exp_tick;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        int ticks;
        int last_p;

        vecs[0]  = '{1, 14, 1, 0, 14, 14, 0};
        vecs[1]  = '{0, 0,  1, 0, 15, 15, 1};
        vecs[2]  = '{0, 0,  1, 0, 0,  15, 1};
        vecs[3]  = '{0, 0,  1, 0, 1,  15, 1};
        vecs[4]  = '{0, 0,  1, 0, 2,  15, 1};
        vecs[5]  = '{1, 1,  1, 1, 1,  1,  0};
        vecs[6]  = '{0, 0,  1, 1, 0,  0,  1};
        vecs[7]  = '{0, 0,  1, 1, 15, 0,  1};
        vecs[8]  = '{1, 9,  1, 0, 9,  9,  0};
        vecs[9]  = '{0, 0,  1, 0, 10, 10, 1};
        vecs[10] = '{0, 0,  0, 0, 10, 10, 0};

        model_reset();
        #1;
        check("reset_out", 0, int'(o_out[0]), 0);
        check("reset_running", 0, int'(o_run[0]), 0);
        check("reset_tick", 0, int'(o_tick[0]), 0);
        step_clk();
        step_clk();

        // Lock bring-up
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) step_clk();
        locked = 1'b1;
        edges_until_running(1'b1, 40, n);
        check("bringup_edges", 0, n, 17 + SYNC_LAT);
        step_clk();
        check("first_count_out", 0, int'(o_out[0]), 1);
        check("first_count_tick", 0, int'(o_tick[0]), 1);

        // Wrap/saturate/load vectors
        foreach (vecs[i]) begin
            load = vecs[i].ld; load_val = W'(vecs[i].lv); en = vecs[i].en; dir = vecs[i].dir;
            step_clk();
            check("vec_out_wrap", i, int'(o_out[0]), vecs[i].exp_w);
            check("vec_out_sat", i, int'(o_out[1]), vecs[i].exp_s);
            check("vec_tick_wrap", i, int'(o_tick[0]), vecs[i].exp_tick);
            check("vec_tick_sat", i, int'(o_tick[1]), vecs[i].exp_tick);
        end

        // Prescale by 5 over 40 enabled cycles
        load = 1'b1; load_val = '0; en = 1'b1; dir = 1'b0;
        step_clk();
        load = 1'b0;
        ticks = 0;
        last_p = int'(o_out[2]);
        for (int i = 0; i < 40; i++) begin
            step_clk();
            if (o_tick[2]) ticks++;
            else check("prescale_hold", 2, int'(o_out[2]), last_p);
            last_p = int'(o_out[2]);
        end
        check("prescale_ticks", 2, ticks, 8);
        check("prescale_out", 2, int'(o_out[2]), 8);

        // Lock glitch mid-SETTLE restarts qualification
        locked = 1'b0;
        edges_until_running(1'b0, 10, n);
        locked = 1'b1;
        for (int i = 0; i < 5; i++) step_clk();
        locked = 1'b0;
        step_clk();
        locked = 1'b1;
        edges_until_running(1'b1, 40, n);
        check("settle_glitch_edges", 0, n, 17 + SYNC_LAT);

        // Lock glitch during RUN with out=7
        load = 1'b1; load_val = 4'd7; en = 1'b0;
        step_clk();
        load = 1'b0; en = 1'b1;
        locked = 1'b0;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            step_clk();
            locked = 1'b1;
            if (!o_run[0]) begin n = i; break; end
        end
        check("run_drop_edges", 0, n, 1 + SYNC_LAT);
        check("run_drop_hold", 0, int'(o_out[0]), 7);
        edges_until_running(1'b1, 40, n);
        check("requal_hold", 0, int'(o_out[0]), 7);
        step_clk();
        check("resume_out", 0, int'(o_out[0]), 8);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            locked   = ($urandom_range(0, 39) != 0);
            en       = ($urandom_range(0, 3) != 0);
            dir      = $urandom_range(0, 1) != 0;
            load     = ($urandom_range(0, 9) == 0);
            load_val = W'($urandom_range(0, 15));
            step_clk();
        end

        // Asynchronous reset mid-count
        locked = 1'b1;
        rst = 1'b1;
        #1;
        check("async_rst_out", 0, int'(o_out[0]), 0);
        check("async_rst_running", 0, int'(o_run[0]), 0);
        check("async_rst_tick", 2, int'(o_tick[2]), 0);
        model_reset();
        step_clk();
        rst = 1'b0;
        step_clk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_gated_counter.md
Name: pll_gated_counter

Overview:
Parametrised successor to the top-level free-running counter that is gated by PLL lock. It qualifies the PLL `locked` signal through a settle window before counting. It adds a prescaler, up/down direction, wrap or saturate mode, and synchronous load. It sits between the clock-generation PLL and any LED/status/heartbeat outputs in a top level.

Parameters:
- WIDTH, 4: counter width in bits.
- PRESCALE, 1: enabled clock cycles per count step; ≥1.
- SETTLE_CYCLES, 16: consecutive qualified-lock cycles required before counting; ≥1.
- SATURATE, 0: 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- clk  in  1  system clock (PLL output domain).
- rst  in  1  asynchronous reset, active-high.
- locked  in  1  PLL lock indicator; may be asynchronous to clk.
- en  in  1  count enable, sampled in RUN only.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- out  out  WIDTH  counter value (registered).
- running  out  1  high while in RUN (registered).
- tick  out  1  one-cycle pulse in the same cycle `out` shows a stepped value (registered).

Behaviour:
- Reset (async assert, sync release): out=0, running=0, tick=0, state=WAIT_LOCK, settle count=0, prescale count=0.
- lock_q is the qualified lock: a synchronised copy of `locked` if LOCK_SYNC_EN is defined, otherwise `locked` itself.
- State machine transitions:
  - WAIT_LOCK: lock_q=1 → SETTLE, scnt←0.
  - SETTLE: lock_q=0 → WAIT_LOCK; else if scnt==SETTLE_CYCLES-1 → RUN; else scnt←scnt+1.
  - RUN: lock_q=0 → WAIT_LOCK.
- Settle timing (no sync): `locked` rises before edge N → running=1 after edge N+SETTLE_CYCLES.
- running is registered and equals (state==RUN).
- Outside RUN:
  - out holds its value; it is not cleared on lock loss.
  - pcnt←0, tick=0.
  - load is ignored.
- In RUN, priority is load > step:
  - load=1: out←load_val, pcnt←0, tick=0 next cycle.
  - en=1 and no load:
    - pcnt<PRESCALE-1: pcnt←pcnt+1.
    - pcnt==PRESCALE-1: pcnt←0, out steps, tick←1.
  - en=0: pcnt and out hold, tick←0.
- Step arithmetic is modulo 2^WIDTH.
  - Up from all-ones: wraps to 0 when SATURATE=0; holds all-ones when SATURATE=1.
  - Down from 0: wraps to all-ones when SATURATE=0; holds 0 when SATURATE=1.
  - A saturated hold still pulses tick.
- dir may change on any cycle; it takes effect at the next step.
- Lock loss in RUN:
  - Next edge: state=WAIT_LOCK, running←0, any step in that cycle suppressed.
  - A load presented in that same cycle is also suppressed.
- Lock loss in SETTLE restarts qualification from scnt=0 on the next lock.
- PRESCALE=1: a step occurs on every enabled RUN cycle; pcnt is constant 0.
- Reset mid-count: all state and outputs return to reset values immediately (async).

Optional Feature:
LOCK_SYNC_EN
- Defined: `locked` passes through a 2-flop synchroniser clocked by clk, reset to 0 by rst. Lock qualification and lock-loss response are delayed 2 cycles.
- Undefined: `locked` is used directly, and the caller guarantees it is synchronous to clk.
- The synchroniser flops carry ASYNC_REG.
- All other behaviour is identical in both builds.

Test Plan:
- Lock bring-up. Setup: no sync, SETTLE_CYCLES=16, en=1; raise locked 3 cycles after rst release. Required: running rises exactly 17 edges after the first edge sampling locked=1; out increments from 0 on each following cycle.
- Prescale. Setup: PRESCALE=5, WIDTH=4, running, en=1, dir=0, for 40 cycles. Required: tick every 5th cycle; out=8 at the end; out stays stable between ticks.
- Wrap vs saturate. Setup: WIDTH=4, load 14, count up 4 steps. Required: SATURATE=0 gives 15,0,1,2; SATURATE=1 gives 15,15,15,15 with tick on each step. Down from load 1 gives 0,15 (wrap) or 0,0 (saturate).
- Load/step collision. Setup: PRESCALE=1; assert load=1 with load_val=9 while en=1. Required: out=9 next cycle with tick=0, then 10 on the following cycle.
- Lock glitch. Setup: drop locked for 1 cycle mid-SETTLE, and separately during RUN with out=7. Required: mid-SETTLE, qualification restarts (full 17 edges again). During RUN, running falls, out holds 7, and counting resumes from 7 after re-qualification.
- LOCK_SYNC_EN build. Setup: repeat the bring-up test. Required: running rises at edge +19, and lock loss drops running 3 edges after the locked fall.
